// File: rtl/accum_pkg.sv
// Shared types for the accumulator bank: operation codes and their width.
package accum_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    LOAD = 2'd2,
    CLR  = 2'd3
  } op_e;

endpackage

// File: rtl/strobe_filter.sv
// Debounces an active-low button level and emits a one-cycle event per accepted
// falling edge. An event needs a high level seen since reset, so a strobe held low through reset is ignored.
module strobe_filter #(
  parameter int DEBOUNCE = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic strobe_ni,
  output logic event_o
);

  logic r_filt;
  logic r_filt_d;
  logic r_armed;

  generate
    if (DEBOUNCE == 0) begin : g_direct
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_filt <= 1'b1;
        else         r_filt <= strobe_ni;
      end
    end else begin : g_debounce
      localparam int CNT_W = $clog2(DEBOUNCE + 1);
      logic [CNT_W-1:0] r_cnt;

      // A new level is taken on the edge after it has differed for DEBOUNCE edges.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_filt <= 1'b1;
          r_cnt  <= '0;
        end else if (strobe_ni == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEBOUNCE)) begin
          r_filt <= strobe_ni;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_filt_d <= 1'b1;
      r_armed  <= 1'b0;
    end else begin
      r_filt_d <= r_filt;
      r_armed  <= r_armed | strobe_ni;
    end
  end

  assign event_o = r_armed & r_filt_d & ~r_filt;

endmodule

// File: rtl/accum_bank.sv
// Bank of NUM_CH accumulators sharing one adder/subtractor, driven by a
// debounced active-low strobe; reports completion, bad channel and sticky overflow.
module accum_bank
  import accum_pkg::*;
#(
  parameter int WIDTH    = 20,
  parameter int NUM_CH   = 4,
  parameter int DEBOUNCE = 0,
  parameter int SATURATE = 0,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    op_ni,
  input  logic [OP_W-1:0]         op_i,
  input  logic [CH_W-1:0]         ch_i,
  input  logic [WIDTH-1:0]        number_i,
  output logic [NUM_CH*WIDTH-1:0] result_o,
  output logic [NUM_CH-1:0]       ovf_o,
  output logic                    done_o,
  output logic                    err_o
);

  logic [WIDTH-1:0]  r_acc [NUM_CH];
  logic [NUM_CH-1:0] r_ovf;
  logic              r_done;
  logic              r_err;

  logic              w_event;
  logic              w_ch_ok;
  op_e               w_op;
  logic [WIDTH-1:0]  w_acc;
  logic [WIDTH:0]    w_sum;
  logic [WIDTH:0]    w_diff;
  logic [WIDTH-1:0]  w_next;
  logic              w_flow;
  logic              w_clr_flag;

  strobe_filter #(.DEBOUNCE(DEBOUNCE)) u_filter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .strobe_ni(op_ni),
    .event_o  (w_event)
  );

  assign w_ch_ok = (32'(ch_i) < NUM_CH);
  assign w_op    = op_e'(op_i);

  // Mux the addressed channel; an out-of-range index reads as zero and is never written.
  always_comb begin
    w_acc = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (32'(ch_i) == k) w_acc = r_acc[k];
    end
  end

  // Carry/borrow lands in the extra top bit.
  assign w_sum  = {1'b0, w_acc} + {1'b0, number_i};
  assign w_diff = {1'b0, w_acc} - {1'b0, number_i};

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_next     = w_acc;
    w_flow     = 1'b0;
    w_clr_flag = 1'b0;
    case (w_op)
      ADD: begin
        w_flow = w_sum[WIDTH];
        w_next = (SATURATE != 0 && w_flow) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
      end
      SUB: begin
        w_flow = w_diff[WIDTH];
        w_next = (SATURATE != 0 && w_flow) ? '0 : w_diff[WIDTH-1:0];
      end
      LOAD: begin
        w_next     = number_i;
        w_clr_flag = 1'b1;
      end
      CLR: begin
        w_next     = '0;
        w_clr_flag = 1'b1;
      end
    endcase
  end

  // NOTE: channel storage is reset explicitly because its value is visible on result_o straight out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_CH; k++) r_acc[k] <= '0;
      r_ovf  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_event & w_ch_ok;
      r_err  <= w_event & ~w_ch_ok;
      if (w_event && w_ch_ok) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (32'(ch_i) == k) begin
            r_acc[k] <= w_next;
            if (w_clr_flag)  r_ovf[k] <= 1'b0;
            else if (w_flow) r_ovf[k] <= 1'b1;
          end
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
      assign result_o[g*WIDTH +: WIDTH] = r_acc[g];
    end
  endgenerate

  assign ovf_o  = r_ovf;
  assign done_o = r_done;
  assign err_o  = r_err;

endmodule

// File: tb/tb_accum_bank.sv
// Two accum_bank instances (wrap/3ch/no debounce and saturate/4ch/debounce 4)
// checked against an integer model of the channel arithmetic and strobe timing.
module tb_accum_bank;
  import accum_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        op_n_a, op_n_b;
  logic [1:0]  op_a, op_b, ch_a, ch_b;
  logic [7:0]  num_a, num_b;
  logic [23:0] res_a;
  logic [31:0] res_b;
  logic [2:0]  ovf_a;
  logic [3:0]  ovf_b;
  logic        done_a, err_a, done_b, err_b;

  int n_total = 0;
  int n_bad   = 0;

  int m_acc [2][4];
  bit m_ovf [2][4];

  always #5 clk = ~clk;

  accum_bank #(.WIDTH(8), .NUM_CH(3), .DEBOUNCE(0), .SATURATE(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .op_ni(op_n_a), .op_i(op_a), .ch_i(ch_a),
    .number_i(num_a), .result_o(res_a), .ovf_o(ovf_a), .done_o(done_a), .err_o(err_a)
  );

  accum_bank #(.WIDTH(8), .NUM_CH(4), .DEBOUNCE(4), .SATURATE(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .op_ni(op_n_b), .op_i(op_b), .ch_i(ch_b),
    .number_i(num_b), .result_o(res_b), .ovf_o(ovf_b), .done_o(done_b), .err_o(err_b)
  );

  function automatic int nch(int w); return (w == 0) ? 3 : 4; endfunction
  function automatic int deb(int w); return (w == 0) ? 0 : 4; endfunction
  function automatic bit sat(int w); return (w != 0); endfunction

  function automatic logic get_done(int w); return (w == 0) ? done_a : done_b; endfunction
  function automatic logic get_err(int w);  return (w == 0) ? err_a  : err_b;  endfunction
  function automatic logic [7:0] get_res(int w, int k);
    return (w == 0) ? res_a[k*8 +: 8] : res_b[k*8 +: 8];
  endfunction
  function automatic logic get_ovf(int w, int k);
    return (w == 0) ? ovf_a[k] : ovf_b[k];
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(int w, logic opn, op_e op, logic [1:0] ch, logic [7:0] num);
    if (w == 0) begin
      op_n_a = opn; op_a = op; ch_a = ch; num_a = num;
    end else begin
      op_n_b = opn; op_b = op; ch_b = ch; num_b = num;
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < 4; k++) begin
        m_acc[w][k] = 0;
        m_ovf[w][k] = 1'b0;
      end
  endtask

  task automatic model_apply(int w, op_e op, int ch, int num);
    int s;
    if (ch >= nch(w)) return;
    case (op)
      ADD: begin
        s = m_acc[w][ch] + num;
        if (s > 255) begin
          m_ovf[w][ch] = 1'b1;
          s = sat(w) ? 255 : s - 256;
        end
        m_acc[w][ch] = s;
      end
      SUB: begin
        s = m_acc[w][ch] - num;
        if (s < 0) begin
          m_ovf[w][ch] = 1'b1;
          s = sat(w) ? 0 : s + 256;
        end
        m_acc[w][ch] = s;
      end
      LOAD: begin m_acc[w][ch] = num; m_ovf[w][ch] = 1'b0; end
      CLR:  begin m_acc[w][ch] = 0;   m_ovf[w][ch] = 1'b0; end
    endcase
  endtask

  task automatic check_state(int w, string tag);
    for (int k = 0; k < nch(w); k++) begin
      check($sformatf("%s dut%0d res%0d", tag, w, k), 32'(get_res(w, k)), m_acc[w][k]);
      check($sformatf("%s dut%0d ovf%0d", tag, w, k), 32'(get_ovf(w, k)), 32'(m_ovf[w][k]));
    end
  endtask

  // Strobe held low for `hold` cycles; pulses are expected exactly 1+DEBOUNCE edges after the fall.
  task automatic do_op(int w, op_e op, int ch, int num, int hold, string tag);
    int  dcount = 0, ecount = 0, pos = -1, both = 0;
    bit  exp_err = (ch >= nch(w));
    @(negedge clk);
    drive(w, 1'b0, op, 2'(ch), 8'(num));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (get_done(w) && get_err(w)) both++;
      if (get_done(w) || get_err(w)) if (pos < 0) pos = i;
      if (get_done(w)) dcount++;
      if (get_err(w))  ecount++;
    end
    model_apply(w, op, ch, num);
    drive(w, 1'b1, op, 2'(ch), 8'(num));
    for (int i = 0; i < deb(w) + 3; i++) begin
      @(negedge clk);
      if (get_done(w)) dcount++;
      if (get_err(w))  ecount++;
    end
    check({tag, " done count"}, dcount, exp_err ? 0 : 1);
    check({tag, " err count"}, ecount, exp_err ? 1 : 0);
    check({tag, " pulse pos"}, pos, 1 + deb(w));
    check({tag, " done&err"}, both, 0);
    check_state(w, tag);
  endtask

  task automatic glitch(int w, int len, string tag);
    int pulses = 0;
    @(negedge clk);
    drive(w, 1'b0, ADD, 2'd0, 8'd1);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (get_done(w) || get_err(w)) pulses++;
    end
    drive(w, 1'b1, ADD, 2'd0, 8'd1);
    for (int i = 0; i < deb(w) + 3; i++) begin
      @(negedge clk);
      if (get_done(w) || get_err(w)) pulses++;
    end
    check({tag, " glitch pulses"}, pulses, 0);
    check_state(w, tag);
  endtask

  initial begin
    int pulses;
    op_e rop;
    rst_n = 1'b0;
    drive(0, 1'b1, ADD, 2'd0, 8'd0);
    drive(1, 1'b1, ADD, 2'd0, 8'd0);
    model_reset();
    repeat (3) @(negedge clk);
    check("reset res_a", 32'(res_a), 0);
    check("reset res_b", res_b, 0);
    check("reset ovf", {ovf_b, ovf_a}, 0);
    check("reset pulses", {done_a, err_a, done_b, err_b}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Wrap-around with sticky overflow.
    do_op(0, LOAD, 0, 250, 4, "a load250");
    do_op(0, ADD, 0, 10, 4, "a add10");
    check("a wrap value", 32'(get_res(0, 0)), 4);
    check("a wrap ovf", 32'(get_ovf(0, 0)), 1);

    // Saturating underflow, then LOAD clears the flag.
    do_op(1, CLR, 1, 0, 8, "b clr");
    do_op(1, SUB, 1, 5, 8, "b sub5");
    check("b sat ovf", 32'(get_ovf(1, 1)), 1);
    do_op(1, LOAD, 1, 7, 8, "b load7");
    check("b load value", 32'(get_res(1, 1)), 7);

    // Out-of-range channel.
    do_op(0, ADD, 3, 9, 4, "a bad ch");

    // Debounce: short glitch ignored, long hold gives one op.
    glitch(1, 3, "b glitch3");
    do_op(1, ADD, 0, 1, 10, "b add1 hold10");

    // Very long hold still counts once.
    do_op(0, ADD, 1, 3, 40, "a long hold");

    for (int n = 0; n < 40; n++) begin
      for (int w = 0; w < 2; w++) begin
        rop = op_e'($urandom_range(0, 3));
        do_op(w, rop, $urandom_range(0, 3),
              ($urandom_range(0, 1) != 0) ? $urandom_range(0, 255) : $urandom_range(240, 255),
              deb(w) + 3 + $urandom_range(0, 4), $sformatf("rand%0d", n));
      end
      if ($urandom_range(0, 3) == 0) glitch(1, $urandom_range(1, 4), $sformatf("rglitch%0d", n));
    end

    // Reset in the middle of a pending operation.
    do_op(0, LOAD, 2, 0, 4, "a rst prep");
    for (int i = 0; i < 3; i++) do_op(0, ADD, 2, 5, 4, "a add5");
    check("a pre-rst ch2", 32'(get_res(0, 2)), 15);
    @(negedge clk);
    drive(0, 1'b0, ADD, 2'd2, 8'd5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid-rst res_a", 32'(res_a), 0);
    check("mid-rst res_b", res_b, 0);
    check("mid-rst ovf", {ovf_b, ovf_a}, 0);
    check("mid-rst pulses", {done_a, err_a, done_b, err_b}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_a || err_a) pulses++;
    end
    check("post-rst held low pulses", pulses, 0);
    check_state(0, "post-rst");
    drive(0, 1'b1, ADD, 2'd2, 8'd5);
    repeat (3) @(negedge clk);
    do_op(0, ADD, 2, 5, 4, "a after rst");
    do_op(1, ADD, 3, 200, 8, "b after rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/accum_bank.md
ACCUM_BANK -- requirements
Module: accum_bank

Interface
REQ-001 Parameter WIDTH, default 20: bit width of each accumulator and of number_i.
REQ-002 Parameter NUM_CH, default 4: number of independent accumulator channels, 1..16.
REQ-003 Parameter DEBOUNCE, default 0: cycles op_ni must hold a new level before it is accepted; 0 disables filtering.
REQ-004 Parameter SATURATE, default 0: 1 saturates results, 0 wraps modulo 2^WIDTH.
REQ-005 clk_i  input  1  single clock; all state updates on rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 op_ni  input  1  active-low operation strobe (button level); a falling edge triggers one operation.
REQ-008 op_i  input  2  operation code: ADD=0, SUB=1, LOAD=2, CLR=3.
REQ-009 ch_i  input  clog2(NUM_CH) (min 1)  target channel index.
REQ-010 number_i  input  WIDTH  unsigned operand.
REQ-011 result_o  output  NUM_CH*WIDTH  registered channel values, channel k at bits [k*WIDTH +: WIDTH].
REQ-012 ovf_o  output  NUM_CH  sticky per-channel overflow/underflow flag.
REQ-013 done_o  output  1  one-cycle pulse after a valid operation completes.
REQ-014 err_o  output  1  one-cycle pulse after an operation addressed to ch_i >= NUM_CH.

Function
REQ-015 Filter: register filt tracks op_ni; DEBOUNCE=0: filt <= op_ni every edge; DEBOUNCE>0: filt takes op_ni's level only after op_ni differs from filt for DEBOUNCE consecutive edges; counter clears whenever op_ni equals filt.
REQ-016 Edge detect: register filt_d <= filt; event = filt_d & ~filt (one cycle per accepted falling edge); rising edges produce no event.
REQ-017 Latency, DEBOUNCE=0: op_ni low at edge N -> channel updated at edge N+1, done_o high during cycle after edge N+1; DEBOUNCE=D adds D edges.
REQ-018 op_i, ch_i, number_i sampled at the edge that applies the event; no earlier capture.
REQ-019 ADD: acc + number_i; SUB: acc - number_i; LOAD: acc <= number_i; CLR: acc <= 0.
REQ-020 Arithmetic in WIDTH+1 bits; carry/borrow out = overflow/underflow event.
REQ-021 SATURATE=1: overflow -> all-ones, underflow -> 0; SATURATE=0: wrap to low WIDTH bits.
REQ-022 ovf_o[k] set on any overflow/underflow event of channel k (either mode); cleared only by LOAD or CLR of channel k or reset.
REQ-023 ch_i >= NUM_CH: no channel or flag changes, err_o pulses instead of done_o.
REQ-024 Only the addressed channel changes; all others hold.
REQ-025 done_o and err_o never high in the same cycle; both 0 absent an event.
REQ-026 op_ni held low indefinitely yields exactly one operation; glitches shorter than DEBOUNCE edges yield none.

Reset
REQ-027 While rst_ni low: result_o=0, ovf_o=0, done_o=0, err_o=0, filt=1, filt_d=1, debounce counter=0.
REQ-028 Reset mid-operation discards any pending event; op_ni already low at release produces no event until it rises and falls again.

Structure
REQ-029 Package accum_pkg holds op_e enum (ADD, SUB, LOAD, CLR) and OP_W=2 constant.
REQ-030 Sub-module strobe_filter implements REQ-015/016 (parameter DEBOUNCE, ports clk_i, rst_ni, strobe_ni, event_o).
REQ-031 Channel storage: array of NUM_CH WIDTH-bit registers, one shared adder/subtractor.

Verification
REQ-032 WIDTH=8, SAT=0: LOAD ch0 250, ADD 10 -> result ch0=4, ovf_o[0]=1, done_o pulses twice.
REQ-033 WIDTH=8, SAT=1: ch1 CLR, SUB 5 -> ch1=0, ovf_o[1]=1; LOAD 7 -> ch1=7, ovf_o[1]=0.
REQ-034 NUM_CH=3: ADD 9 to ch_i=3 -> err_o one pulse, all channels unchanged, done_o=0.
REQ-035 DEBOUNCE=4: op_ni low 3 cycles then high -> no change; low 10 cycles with ADD 1 -> exactly +1, done_o 6 edges after fall.
REQ-036 ADD 5 to ch2 three times, assert rst_ni low mid-hold of 4th strobe -> all outputs 0 immediately; after release with op_ni still low, no update.
